// File: rtl/lcd_timing_pattern_gen.sv
// Parametrised RGB-LCD timing generator with a built-in test-pattern source.
// Optional build macro SCROLL_EN adds a horizontal scroll to the bars/checker patterns.
module lcd_timing_pattern_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 32,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  parameter int CHK_LOG2 = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [1:0]     MODE,
  input  logic           MODE_VLD,
  input  logic [23:0]    SOLID_RGB,
  output logic           LCD_DE,
  output logic           LCD_HSYNC,
  output logic           LCD_VSYNC,
  output logic [R_W-1:0] LCD_R,
  output logic [G_W-1:0] LCD_G,
  output logic [B_W-1:0] LCD_B,
  output logic           FRAME_START,
  output logic [7:0]     FRAME_CNT
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] BW       = 32'(H_ACTIVE / 8);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_ACTIVE < 8) begin : g_bad_params
    $error("lcd_timing_pattern_gen: porch/sync values must be >= 1 and H_ACTIVE >= 8");
  end

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0]    mode_act;
  logic [1:0]    mode_pend;
  logic [31:0]   x32, y32, xp, sum32;
  logic          frame_end;
  logic          de_n, hs_n, vs_n, chk;
  logic [2:0]    bar;
  logic [R_W-1:0] r_n;
  logic [G_W-1:0] g_n;
  logic [B_W-1:0] b_n;

  assign x32       = 32'(hcnt);
  assign y32       = 32'(vcnt);
  assign sum32     = x32 + y32;
  assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);

`ifdef SCROLL_EN
  logic [HW-1:0] xoff;
  logic [31:0]   xe;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      xoff <= '0;
    end else if (frame_end) begin
      xoff <= (32'(xoff) == 32'(H_ACTIVE - 1)) ? '0 : xoff + HW'(1);
    end
  end

  assign xe = x32 + 32'(xoff);
  assign xp = (xe >= 32'(H_ACTIVE)) ? xe - 32'(H_ACTIVE) : xe;
`else
  assign xp = x32;
`endif

  // Full vectors are referenced so partially used bits do not count as dangling.
  logic unused_ok;
  assign unused_ok = ^{SOLID_RGB, x32, y32, xp, sum32};

  always_comb begin
    de_n = (x32 < 32'(H_ACTIVE)) && (y32 < 32'(V_ACTIVE));
    hs_n = (x32 >= HS_START && x32 < HS_END) ? HS_POL : ~HS_POL;
    vs_n = (y32 >= VS_START && y32 < VS_END) ? VS_POL : ~VS_POL;
    chk  = xp[CHK_LOG2] ^ y32[CHK_LOG2];
    if      (xp < BW)        bar = 3'b111;
    else if (xp < BW * 2)    bar = 3'b110;
    else if (xp < BW * 3)    bar = 3'b011;
    else if (xp < BW * 4)    bar = 3'b010;
    else if (xp < BW * 5)    bar = 3'b101;
    else if (xp < BW * 6)    bar = 3'b100;
    else if (xp < BW * 7)    bar = 3'b001;
    else                     bar = 3'b000;
    r_n = '0;
    g_n = '0;
    b_n = '0;
    case (mode_act)
      2'd0: begin
        r_n = SOLID_RGB[23 -: R_W];
        g_n = SOLID_RGB[15 -: G_W];
        b_n = SOLID_RGB[7 -: B_W];
      end
      2'd1: begin
        r_n = {R_W{bar[2]}};
        g_n = {G_W{bar[1]}};
        b_n = {B_W{bar[0]}};
      end
      2'd2: begin
        r_n = {R_W{~chk}};
        g_n = {G_W{~chk}};
        b_n = {B_W{~chk}};
      end
      default: begin
        r_n = x32[R_W-1:0];
        g_n = y32[G_W-1:0];
        b_n = sum32[B_W-1:0];
      end
    endcase
    if (!de_n) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hcnt        <= '0;
      vcnt        <= '0;
      mode_act    <= 2'd0;
      mode_pend   <= 2'd0;
      LCD_DE      <= 1'b0;
      LCD_HSYNC   <= ~HS_POL;
      LCD_VSYNC   <= ~VS_POL;
      LCD_R       <= '0;
      LCD_G       <= '0;
      LCD_B       <= '0;
      FRAME_START <= 1'b0;
      FRAME_CNT   <= 8'd0;
    end else begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
      if (MODE_VLD) mode_pend <= MODE;
      // A strobe landing on the frame-end cycle bypasses the pending register.
      if (frame_end) begin
        mode_act  <= MODE_VLD ? MODE : mode_pend;
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
      LCD_DE      <= de_n;
      LCD_HSYNC   <= hs_n;
      LCD_VSYNC   <= vs_n;
      LCD_R       <= r_n;
      LCD_G       <= g_n;
      LCD_B       <= b_n;
      FRAME_START <= (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Bench for lcd_timing_pattern_gen: small 16x8 raster, random stimulus against a
// frame-level reference model; build with +define+SCROLL_EN to exercise scrolling.
module tb_lcd_timing_pattern_gen;
  localparam int HA = 16, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 8,  VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  MODE;
  logic        MODE_VLD;
  logic [23:0] SOLID_RGB;
  logic        LCD_DE, LCD_HSYNC, LCD_VSYNC, FRAME_START;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic [7:0]  FRAME_CNT;

  lcd_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .R_W(5), .G_W(6), .B_W(5), .CHK_LOG2(2)
  ) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .MODE_VLD(MODE_VLD), .SOLID_RGB(SOLID_RGB),
    .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
    .FRAME_START(FRAME_START), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int t, act_m, pend_m, fcnt_m, xoff_m;
  logic [2:0] bar_col [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(int mode, int x, int y, logic [23:0] solid, int xoff);
    int xe, idx;
    logic [2:0] c;
    xe = (x + xoff) % HA;
    case (mode)
      0: return {solid[23:19], solid[15:10], solid[7:3]};
      1: begin
        idx = xe / (HA / 8);
        if (idx > 7) idx = 7;
        c = bar_col[idx];
        return {{5{c[2]}}, {6{c[1]}}, {5{c[0]}}};
      end
      2: return ((((xe >> 2) ^ (y >> 2)) & 1) == 0) ? 16'hFFFF : 16'h0000;
      default: return {5'(x % 32), 6'(y % 64), 5'((x + y) % 32)};
    endcase
  endfunction

  task automatic step(input bit vld, input logic [1:0] m);
    int h, v, xo;
    logic e_de, e_hs, e_vs, e_fs;
    logic [15:0] e_pix;
    h = t % HT;
    v = t / HT;
    MODE_VLD  = vld;
    MODE      = m;
    SOLID_RGB = 24'($urandom);
`ifdef SCROLL_EN
    xo = xoff_m;
`else
    xo = 0;
`endif
    e_de  = (h < HA) && (v < VA);
    e_hs  = !((h >= HA + HF) && (h < HA + HF + HSW));
    e_vs  = !((v >= VA + VF) && (v < VA + VF + VSW));
    e_fs  = (t == 0);
    e_pix = e_de ? exp_pix(act_m, h, v, SOLID_RGB, xo) : 16'h0000;
    if (vld) pend_m = m;
    if (t == FT - 1) begin
      act_m  = pend_m;
      fcnt_m = (fcnt_m + 1) % 256;
      xoff_m = (xoff_m + 1) % HA;
    end
    t = (t + 1) % FT;
    @(posedge CLK);
    #1;
    MODE_VLD = 1'b0;
    chk($sformatf("de h%0d v%0d", h, v), 32'(LCD_DE), 32'(e_de));
    chk($sformatf("hsync h%0d v%0d", h, v), 32'(LCD_HSYNC), 32'(e_hs));
    chk($sformatf("vsync h%0d v%0d", h, v), 32'(LCD_VSYNC), 32'(e_vs));
    chk($sformatf("rgb h%0d v%0d", h, v), 32'({LCD_R, LCD_G, LCD_B}), 32'(e_pix));
    chk($sformatf("frame_start h%0d v%0d", h, v), 32'(FRAME_START), 32'(e_fs));
    chk($sformatf("frame_cnt h%0d v%0d", h, v), 32'(FRAME_CNT), 32'(fcnt_m));
  endtask

  task automatic run(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(99) < pct, 2'($urandom_range(3)));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " de"}, 32'(LCD_DE), 32'd0);
    chk({tag, " hsync"}, 32'(LCD_HSYNC), 32'd1);
    chk({tag, " vsync"}, 32'(LCD_VSYNC), 32'd1);
    chk({tag, " rgb"}, 32'({LCD_R, LCD_G, LCD_B}), 32'd0);
    chk({tag, " frame_start"}, 32'(FRAME_START), 32'd0);
    chk({tag, " frame_cnt"}, 32'(FRAME_CNT), 32'd0);
  endtask

  initial begin
    RST = 1'b1; MODE = 2'd0; MODE_VLD = 1'b0; SOLID_RGB = 24'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals("reset");
    RST = 1'b0;
    t = 0; act_m = 0; pend_m = 0; fcnt_m = 0; xoff_m = 0;

    // frame A: solid, request bars
    run(30, 0);
    step(1'b1, 2'd1);
    run(FT - 31, 0);
    // frame B: bars; two strobes, the later (gradient) wins
    run(40, 0);
    step(1'b1, 2'd2);
    run(50, 0);
    step(1'b1, 2'd3);
    run(FT - 92, 0);
    // frame C: gradient; strobe checker exactly on the frame-end cycle
    run(FT - 1, 0);
    step(1'b1, 2'd2);
    // frame D: checker, then a frame of random strobes
    run(FT, 0);
    run(FT, 10);
    // reset while the counters sit at hcnt=7, vcnt=4
    run(4 * HT + 7, 10);
    RST = 1'b1;
    #1;
    check_reset_vals("midframe_reset");
    t = 0; act_m = 0; pend_m = 0; fcnt_m = 0; xoff_m = 0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    // solid frame requesting bars, then long bars run across the scroll wrap
    run(20, 0);
    step(1'b1, 2'd1);
    run(FT - 21, 0);
    run(17 * FT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
